// File: rtl/stream_dispatch_pkg.sv
// Shared definitions for the 1-to-3 stream dispatcher: header field
// positions, the broadcast destination code and the dispatcher FSM states.
package stream_dispatch_pkg;

  // Header word layout
  localparam int DEST_LSB = 0;
  localparam int DEST_MSB = 1;
  localparam int LEN_LSB  = 16;
  localparam int LEN_MSB  = 31;

  // Destination code that targets every output
  localparam logic [1:0] DEST_BCAST = 2'd3;

  // Number of output channels
  localparam int N_OUT = 3;

  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous single-clock FIFO. A push while full is dropped even if a pop
// happens in the same cycle; a pop while empty is ignored.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stream_dispatch_1to3.sv
// 1-to-3 packet dispatcher. A header word selects one output (or all three)
// and a payload length; the following payload words are buffered in
// per-output FIFOs. Headers are consumed and never forwarded.
//
// Handshake: on every channel a word moves only in a cycle where vld and ack
// are both high at the rising clock edge. vld never waits for ack; the
// inbound ack is derived from state and FIFO fullness only, never from vld.
module stream_dispatch_1to3
  import stream_dispatch_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1,
  input  logic                    vld_interface2user_1,
  output logic                    ack_user2interface_1,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_2,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_3,
  output logic                    vld_user2interface_1,
  output logic                    vld_user2interface_2,
  output logic                    vld_user2interface_3,
  input  logic                    ack_interface2user_1,
  input  logic                    ack_interface2user_2,
  input  logic                    ack_interface2user_3,
  output logic                    busy,
  output logic                    state_dbg
);

  state_t      state, state_nxt;
  logic [1:0]  dest_q, dest_nxt;
  logic [15:0] remaining_q, remaining_nxt;

  logic [N_OUT-1:0] full, empty, push, pop, ack_out;
  logic [PAYLOAD_BITS-1:0] head [N_OUT];

  logic [1:0]  hdr_dest;
  logic [15:0] hdr_len;

  assign hdr_dest = dout_leaf_interface2user_1[DEST_MSB:DEST_LSB];
  assign hdr_len  = dout_leaf_interface2user_1[LEN_MSB:LEN_LSB];
  assign ack_out  = {ack_interface2user_3, ack_interface2user_2, ack_interface2user_1};

  // State, latched destination and remaining-word counter
  always_ff @(posedge clk_user) begin
    if (reset) begin
      state       <= HDR;
      dest_q      <= '0;
      remaining_q <= '0;
    end else begin
      state       <= state_nxt;
      dest_q      <= dest_nxt;
      remaining_q <= remaining_nxt;
    end
  end

  // Header decode, inbound ack and FIFO push selection
  always_comb begin
    state_nxt            = state;
    dest_nxt             = dest_q;
    remaining_nxt        = remaining_q;
    ack_user2interface_1 = 1'b1;
    push                 = '0;
    case (state)
      HDR: begin
        ack_user2interface_1 = 1'b1;
        // Zero-length headers are swallowed and we stay waiting for a header
        if (vld_interface2user_1 && (hdr_len != 16'd0)) begin
          dest_nxt      = hdr_dest;
          remaining_nxt = hdr_len;
          state_nxt     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (dest_q == DEST_BCAST) ack_user2interface_1 = ~|full;
        else                      ack_user2interface_1 = ~full[dest_q];
        if (vld_interface2user_1 && ack_user2interface_1) begin
          push          = (dest_q == DEST_BCAST) ? 3'b111 : (3'b001 << dest_q);
          remaining_nxt = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_nxt = HDR;
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  assign pop = ~empty & ack_out;

  for (genvar g = 0; g < N_OUT; g++) begin : g_fifo
    stream_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_user),
      .reset (reset),
      .push  (push[g]),
      .wdata (dout_leaf_interface2user_1),
      .pop   (pop[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  assign vld_user2interface_1      = ~empty[0];
  assign vld_user2interface_2      = ~empty[1];
  assign vld_user2interface_3      = ~empty[2];
  assign din_leaf_user2interface_1 = head[0];
  assign din_leaf_user2interface_2 = head[1];
  assign din_leaf_user2interface_3 = head[2];

  assign busy      = (state == PAYLOAD) | ~&empty;
  assign state_dbg = (state == PAYLOAD);

endmodule

// File: tb/tb_stream_dispatch_1to3.sv
// Bench for stream_dispatch_1to3: directed packet scenarios plus a long
// random run. Expected words are queued per output when the bench hands a
// payload word to the DUT; a monitor pops and compares on output transfers.
module tb_stream_dispatch_1to3;

  localparam int W = 32;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk_user = 1'b0;
  logic reset;
  always #5 clk_user = ~clk_user;

  logic [W-1:0] din_in;
  logic         vld_in;
  logic         ack_in;
  logic [W-1:0] dout [3];
  logic [2:0]   vld_o;
  logic [2:0]   ack_o;
  logic         busy;
  logic         state_dbg;

  stream_dispatch_1to3 #(.PAYLOAD_BITS(W), .FIFO_DEPTH(D)) dut (
    .clk_user                   (clk_user),
    .reset                      (reset),
    .dout_leaf_interface2user_1 (din_in),
    .vld_interface2user_1       (vld_in),
    .ack_user2interface_1       (ack_in),
    .din_leaf_user2interface_1  (dout[0]),
    .din_leaf_user2interface_2  (dout[1]),
    .din_leaf_user2interface_3  (dout[2]),
    .vld_user2interface_1       (vld_o[0]),
    .vld_user2interface_2       (vld_o[1]),
    .vld_user2interface_3       (vld_o[2]),
    .ack_interface2user_1       (ack_o[0]),
    .ack_interface2user_2       (ack_o[1]),
    .ack_interface2user_3       (ack_o[2]),
    .busy                       (busy),
    .state_dbg                  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q [3][$];
  int total = 0;
  int bad   = 0;
  int pay_cnt = 0;
  int mode [3];   // 0 = random ack, 1 = held high, 2 = held low

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference routing: dest 0..2 -> that output, dest 3 -> all outputs
  task automatic push_exp(input logic [1:0] d, input logic [W-1:0] w);
    if (d == 2'd3) begin
      for (int k = 0; k < 3; k++) exp_q[k].push_back(w);
    end else begin
      exp_q[d].push_back(w);
    end
  endtask

  // ---------------- output ack driver ----------------
  always @(posedge clk_user) begin
    #1;
    for (int k = 0; k < 3; k++)
      ack_o[k] = (mode[k] == 0) ? ($urandom_range(0, 3) != 0) : (mode[k] == 1);
  end

  // ---------------- monitor ----------------
  always @(negedge clk_user) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (vld_o[k] && ack_o[k]) begin
          if (exp_q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL out%0d_unexpected: got %h want none", k + 1, dout[k]);
          end else begin
            check($sformatf("out%0d_data", k + 1), dout[k], exp_q[k].pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_user);
      #1;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit pay, input logic [1:0] d);
    int  waited = 0;
    bit  done   = 0;
    din_in = w;
    vld_in = 1'b1;
    while (!done) begin
      @(negedge clk_user);
      if (ack_in) begin
        if (pay) begin
          push_exp(d, w);
          pay_cnt++;
        end
        done = 1;
      end else if (++waited > 500) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got no ack want ack within 500 cycles");
        done = 1;
      end
      @(posedge clk_user);
      #1;
    end
    vld_in = 1'b0;
  endtask

  task automatic send_packet(input logic [1:0] d, input int len, input bit gaps);
    logic [W-1:0] hdr;
    hdr = {len[15:0], 14'($urandom), d};
    send_word(hdr, 1'b0, d);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) idle(1);
      send_word($urandom, 1'b1, d);
    end
  endtask

  task automatic set_modes(input int m);
    for (int k = 0; k < 3; k++) mode[k] = m;
  endtask

  task automatic drain(input string name);
    int n = 0;
    set_modes(1);
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || busy) && n < 300) begin
      idle(1);
      n++;
    end
    @(negedge clk_user);
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_left"}, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 32'd0);
    @(posedge clk_user);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    reset  = 1'b1;
    vld_in = 1'b0;
    din_in = '0;
    ack_o  = '0;
    set_modes(1);
    repeat (3) @(posedge clk_user);
    #1;
    reset = 1'b0;

    // Post-reset outputs
    @(negedge clk_user);
    check("rst_vld",   {29'b0, vld_o}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_ack",   {31'b0, ack_in}, 32'd1);
    check("rst_state", {31'b0, state_dbg}, 32'd0);
    @(posedge clk_user);
    #1;

    // Unicast dest 1, LEN 3: first word visible the cycle after acceptance
    send_word(32'h0003_0001, 1'b0, 2'd1);
    send_word(32'hA, 1'b1, 2'd1);
    @(negedge clk_user);
    check("uni_lat_vld",  {29'b0, vld_o}, 32'b010);
    check("uni_lat_data", dout[1], 32'hA);
    @(posedge clk_user);
    #1;
    send_word(32'hB, 1'b1, 2'd1);
    send_word(32'hC, 1'b1, 2'd1);
    drain("uni");

    // Broadcast with output 3 stalled
    mode[2] = 2;
    idle(1);
    send_word(32'h0002_0003, 1'b0, 2'd3);
    send_word(32'h11, 1'b1, 2'd3);
    send_word(32'h22, 1'b1, 2'd3);
    idle(3);
    @(negedge clk_user);
    check("bc_hold_vld",  {31'b0, vld_o[2]}, 32'd1);
    check("bc_hold_data", dout[2], 32'h11);
    check("bc_12_done",   {30'b0, vld_o[1:0]}, 32'd0);
    @(posedge clk_user);
    #1;
    drain("bc");

    // Dest 0, LEN 6 into a stalled output: only FIFO_DEPTH words fit
    mode[0] = 2;
    idle(1);
    base = pay_cnt;
    fork
      begin
        send_word(32'h0006_0000, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) send_word(32'h100 + i, 1'b1, 2'd0);
      end
    join_none
    idle(20);
    @(negedge clk_user);
    check("stall_accepted", pay_cnt - base, 32'd4);
    check("stall_ack",      {31'b0, ack_in}, 32'd0);
    @(posedge clk_user);
    #1;
    mode[0] = 1;
    wait fork;
    drain("stall");

    // Zero-length header, then a header whose dest is 0 and LEN 1
    send_word(32'h0000_0002, 1'b0, 2'd2);
    @(negedge clk_user);
    check("len0_vld",   {29'b0, vld_o}, 32'd0);
    check("len0_state", {31'b0, state_dbg}, 32'd0);
    @(posedge clk_user);
    #1;
    send_word(32'h0001_0000, 1'b0, 2'd0);
    @(negedge clk_user);
    check("hdr2_state", {31'b0, state_dbg}, 32'd1);
    @(posedge clk_user);
    #1;
    send_word(32'h5A, 1'b1, 2'd0);
    drain("len0");

    // Reset mid-packet after 2 of 5 broadcast words
    set_modes(2);
    idle(1);
    send_word(32'h0005_0003, 1'b0, 2'd3);
    send_word(32'h31, 1'b1, 2'd3);
    send_word(32'h32, 1'b1, 2'd3);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    @(posedge clk_user);
    #1;
    reset = 1'b0;
    @(negedge clk_user);
    check("mid_rst_vld",  {29'b0, vld_o}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ack",  {31'b0, ack_in}, 32'd1);
    @(posedge clk_user);
    #1;
    set_modes(1);
    send_word(32'h0001_0002, 1'b0, 2'd2);
    @(negedge clk_user);
    check("mid_rst_hdr", {31'b0, state_dbg}, 32'd1);
    @(posedge clk_user);
    #1;
    send_word(32'h77, 1'b1, 2'd2);
    drain("mid_rst");

    // Random packets with random input gaps and random output acks
    set_modes(0);
    for (int p = 0; p < 10000; p++) begin
      send_packet(2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b1);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_dispatch_1to3.md
STREAM_DISPATCH_1TO3 -- requirements
Module: stream_dispatch_1to3

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32: width of every data port.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2: entries per output FIFO.
REQ-003 SHALL have port clk_user, input, 1: the single clock; every flop is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port dout_leaf_interface2user_1, input, PAYLOAD_BITS: inbound word from the leaf interface.
REQ-006 SHALL have port vld_interface2user_1, input, 1: inbound word valid.
REQ-007 SHALL have port ack_user2interface_1, output, 1: inbound word accepted.
REQ-008 SHALL have ports din_leaf_user2interface_1/2/3, output, PAYLOAD_BITS each: outbound words.
REQ-009 SHALL have ports vld_user2interface_1/2/3, output, 1 each: outbound valid.
REQ-010 SHALL have ports ack_interface2user_1/2/3, input, 1 each: outbound accepted.
REQ-011 SHALL have port busy, output, 1: high while in PAYLOAD state or while any FIFO is non-empty.

Function
REQ-012 SHALL transfer a word on any channel only in a cycle where that channel's vld and ack are both high.
REQ-013 SHALL treat the first inbound word after reset, and the first word after each completed packet, as a header: bits[1:0] = dest, bits[31:16] = LEN payload words.
REQ-014 SHALL map dest 0/1/2 to outputs 1/2/3, and dest 3 to broadcast to all three outputs.
REQ-015 SHALL NOT forward header words to any output.
REQ-016 SHALL implement two states: HDR (reset state) and PAYLOAD.
REQ-017 SHALL, in HDR, drive ack_user2interface_1=1 unconditionally.
REQ-018 SHALL, on a header transfer with LEN=0, remain in HDR and produce no output.
REQ-019 SHALL, on a header transfer with LEN>0, latch dest, load a 16-bit remaining counter with LEN, and enter PAYLOAD.
REQ-020 SHALL, in PAYLOAD, derive ack_user2interface_1 combinationally from state and FIFO status only, never from vld_interface2user_1.
REQ-021 SHALL, in PAYLOAD with unicast dest, set ack_user2interface_1 = NOT full of the target FIFO.
REQ-022 SHALL, in PAYLOAD with broadcast dest, set ack_user2interface_1 = NOT full of all three FIFOs, and push each accepted word into all three FIFOs in the same cycle.
REQ-023 SHALL decrement the remaining counter on each payload transfer, and return to HDR on the transfer that makes it 0.
REQ-024 SHALL NOT allow a full FIFO to be pushed, even if it pops in the same cycle.
REQ-025 SHALL allow simultaneous push and pop on a non-full, non-empty FIFO, with occupancy unchanged.
REQ-026 SHALL drive vld_user2interface_k = FIFO k non-empty, and din_leaf_user2interface_k = FIFO k head word.
REQ-027 SHALL present a payload word accepted at cycle N on its output(s) at cycle N+1 when the FIFO was empty.
REQ-028 SHALL preserve word order per output, wrapping FIFO pointers modulo FIFO_DEPTH.
REQ-029 SHALL drain each output FIFO independently; a stalled output blocks input only when that output is a target.

Reset
REQ-030 SHALL, while reset is high at a clock edge, set state to HDR, the remaining counter to 0, and all FIFO pointers and counts to 0.
REQ-031 SHALL, in the cycle after reset, hold vld_user2interface_1/2/3=0, busy=0, and ack_user2interface_1=1.
REQ-032 SHALL, on reset asserted mid-packet, discard buffered words, and treat the next inbound word as a header.
REQ-033 SHALL leave data outputs don't-care while their vld is 0.

Structure
REQ-034 SHALL place the following in package stream_dispatch_pkg:
- header field positions (DEST_LSB/MSB, LEN_LSB/MSB);
- DEST_BCAST=2'd3;
- the state enum {HDR, PAYLOAD}.
REQ-035 SHALL use one sub-module, stream_fifo: a synchronous FIFO with push/pop/full/empty/head ports, parameterised by width and depth, instantiated three times.

Verification
REQ-036 SHALL cover: header 0x0003_0001 (dest 1, LEN 3), then 0xA, 0xB, 0xC, all acks high -> output 2 emits A, B, C at cycles +1..+3; outputs 1 and 3 stay idle.
REQ-037 SHALL cover: header 0x0002_0003 (broadcast), then 0x11, 0x22, with ack_interface2user_3=0 -> outputs 1 and 2 emit both words; output 3 holds 0x11 valid until ack, then emits 0x22.
REQ-038 SHALL cover: dest 0, LEN 6, ack_interface2user_1=0 -> exactly 4 words accepted, ack_user2interface_1 low; releasing ack drains all 6 words in order.
REQ-039 SHALL cover: header 0x0000_0002 (LEN 0) then header 0x0001_0000 -> no output; second word taken as header, state PAYLOAD with dest 0.
REQ-040 SHALL cover: reset pulsed after 2 of 5 payload words -> vld outputs 0 next cycle; next inbound 0x0001_0002 decoded as header.
REQ-041 SHALL cover: random vld/ack toggling over 10^4 packets -> per-output scoreboard matches, no drop or duplicate.
